// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the capture-path FIFO burst reader.
// Latency: none; this file holds type definitions only.
// Backpressure: not applicable.
package fifo_burst_reader_pkg;

  // Burst engine states: wait for data, request a burst, stream its words
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// burst_skid_buffer: 2-entry register FIFO of {pad, data} words between the FIFO read strobe and the output port.
// Latency: a pushed word is visible at the head on the following cycle; push and pop may occur in the same cycle.
// Backpressure: none internally; the owner pushes only with a free slot and pops only when not empty.
module burst_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_push_pad,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [1:0]       o_count,
  output logic             o_head_pad,
  output logic [WIDTH-1:0] o_head_dat
);

  logic [WIDTH-1:0] r_dat [2];
  logic [1:0]       r_pad;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat[0] <= '0;
      r_dat[1] <= '0;
      r_pad    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_dat[r_wr_ptr] <= i_push_dat;
        r_pad[r_wr_ptr] <= i_push_pad;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count    = r_count;
  assign o_head_pad = r_pad[r_rd_ptr];
  assign o_head_dat = r_dat[r_rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains the capture CDC FIFO into fixed-length bursts, padding a flushed tail to full length.
// Latency: first word appears 2 cycles after its dequeue; one burst request/ack handshake precedes each burst.
// Backpressure: out_ready stalls delivery; reads stop once skid buffer plus in-flight word would exceed 2 entries.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               BURST_LEN = 16,
  parameter logic [WIDTH-1:0] PAD_WORD  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_filled,
  output logic             fifo_dequeue,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             flush,
  output logic             burst_req,
  input  logic             burst_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_pad,
  output logic             busy
);

  localparam int             CW     = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0]  C_LEN  = CW'(BURST_LEN);
  localparam logic [CW-1:0]  C_LAST = CW'(BURST_LEN - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_flush_mode;
  logic            r_inflight;
  logic            r_inflight_pad;
  logic [CW-1:0]   r_issued;
  logic [CW-1:0]   r_sent;

  logic [1:0]       w_count;
  logic             w_head_pad;
  logic [WIDTH-1:0] w_head_dat;
  logic             w_credit;
  logic             w_can_launch;
  logic             w_launch_pad;
  logic             w_launch;
  logic             w_xfer;

  // A launch needs room for itself: buffered words plus the word in flight must leave a slot free
  assign w_credit     = ({1'b0, w_count} + {2'b00, r_inflight}) <= 3'd1;
  assign w_can_launch = (r_state == ST_STREAM) && (r_issued < C_LEN) && w_credit;
  assign fifo_dequeue = w_can_launch && !fifo_empty;
  assign w_launch_pad = w_can_launch && fifo_empty && r_flush_mode;
  assign w_launch     = fifo_dequeue || w_launch_pad;

  assign out_valid = (w_count != 2'd0);
  assign out_data  = w_head_dat;
  assign out_pad   = w_head_pad && out_valid;
  assign out_last  = (r_sent == C_LAST);
  assign w_xfer    = out_valid && out_ready;
  assign busy      = (r_state != ST_IDLE);

  // Next-state and burst request; flush is only looked at while idle
  always_comb begin
    w_state_nxt = r_state;
    burst_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fifo_filled || (flush && !fifo_empty)) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        burst_req = 1'b1;
        if (burst_ack) begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_xfer && out_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush latch, in-flight tracking and issue/delivery counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_mode   <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_pad <= 1'b0;
      r_issued       <= '0;
      r_sent         <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_REQ)) begin
        r_flush_mode <= flush;
      end
      r_inflight     <= w_launch;
      r_inflight_pad <= w_launch_pad;
      if (w_xfer && out_last) begin
        r_issued <= '0;
        r_sent   <= '0;
      end else begin
        if (w_launch) begin
          r_issued <= r_issued + CW'(1);
        end
        if (w_xfer) begin
          r_sent <= r_sent + CW'(1);
        end
      end
    end
  end

  // The FIFO's registered read data is valid the cycle after the dequeue, alongside r_inflight
  burst_skid_buffer #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_inflight),
    .i_push_pad (r_inflight_pad),
    .i_push_dat (r_inflight_pad ? PAD_WORD : fifo_rdata),
    .i_pop      (w_xfer),
    .o_count    (w_count),
    .o_head_pad (w_head_pad),
    .o_head_dat (w_head_dat)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader with BURST_LEN=4: directed scenarios plus a randomized drain run.
// Latency: a FIFO model returns read data one cycle after each dequeue.
// Backpressure: out_ready and burst_ack are driven in fixed, toggling, delayed or random patterns.
module tb_fifo_burst_reader;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_filled;
  logic       fifo_dequeue;
  logic [7:0] fifo_rdata;
  logic       flush;
  logic       burst_req;
  logic       burst_ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_pad;
  logic       busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH     (8),
    .BURST_LEN (BL),
    .PAD_WORD  (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_filled  (fifo_filled),
    .fifo_dequeue (fifo_dequeue),
    .fifo_rdata   (fifo_rdata),
    .flush        (flush),
    .burst_req    (burst_req),
    .burst_ack    (burst_ack),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_pad      (out_pad),
    .busy         (busy)
  );

  typedef struct { logic [7:0] d; logic p; logic l; } word_t;
  typedef struct { int scen; logic [7:0] exp_dat; logic exp_pad; logic exp_last; } vec_t;

  vec_t       tbl [12];
  word_t      cap [$];
  logic [7:0] fq [$];
  logic [7:0] src [$];
  logic [7:0] expq [$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_mode, ready_mode, filled_force, ack_hold;
  int   cyc_no, first_deq, first_vld, n_deq, n_xfer, low_ack_cycles;
  bit   feed_en, feed_rand, chk_ackwait, hs_pending, prev_vld_nr, prev_last_xfer;
  logic [7:0] prev_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: observe at the falling edge, then drive the environment just after the rising edge
  task automatic cyc();
    bit    deq;
    bit    req_s;
    word_t w;
    @(negedge clk);
    cyc_no++;
    deq   = fifo_dequeue;
    req_s = burst_req;
    if (rst) begin
      n_deq = 0; n_xfer = 0; prev_vld_nr = 0; prev_last_xfer = 0; hs_pending = 0;
    end else begin
      if (fifo_dequeue) begin
        chk("deq_not_empty", fifo_empty, 0);
        chk("credit", (n_deq - n_xfer) <= 1, 1);
        if (first_deq < 0) first_deq = cyc_no;
      end
      if (out_valid && first_vld < 0) first_vld = cyc_no;
      if (prev_vld_nr) begin
        chk("valid_hold", out_valid, 1);
        chk("data_hold", out_data, prev_dat);
      end
      if (prev_last_xfer) chk("busy_drop", busy, 0);
      if (chk_ackwait && hs_pending) begin
        chk("stream_start_deq", fifo_dequeue, 1);
        chk("stream_start_req", burst_req, 0);
        hs_pending = 0;
      end
      if (burst_req && !burst_ack) begin
        low_ack_cycles++;
        if (chk_ackwait) begin
          chk("wait_no_deq", fifo_dequeue, 0);
          chk("wait_no_vld", out_valid, 0);
        end
      end
      if (chk_ackwait && burst_req && burst_ack) hs_pending = 1;
      prev_vld_nr    = out_valid && !out_ready;
      prev_dat       = out_data;
      prev_last_xfer = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        w.d = out_data; w.p = out_pad; w.l = out_last;
        cap.push_back(w);
        n_xfer++;
      end
      if (deq) n_deq++;
    end
    @(posedge clk);
    #1;
    if (deq && fq.size() > 0) fifo_rdata = fq.pop_front();
    if (feed_en && src.size() > 0 && (!feed_rand || $urandom_range(0, 1) == 1))
      fq.push_back(src.pop_front());
    fifo_empty  = (fq.size() == 0);
    fifo_filled = (filled_force == 1) ? 1'b1 : (fq.size() >= BL);
    case (ack_mode)
      0:       burst_ack = 1'b1;
      1:       burst_ack = req_s;
      2:       burst_ack = (low_ack_cycles >= ack_hold);
      default: burst_ack = 1'($urandom_range(0, 1));
    endcase
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Compare captured words against one scenario of the vector table
  task automatic cmp_tbl(input int scen, input string nm);
    int k = 0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].scen == scen) begin
        if (k < cap.size()) begin
          chk($sformatf("%s_dat%0d", nm, k), cap[k].d, tbl[i].exp_dat);
          chk($sformatf("%s_pad%0d", nm, k), cap[k].p, tbl[i].exp_pad);
          chk($sformatf("%s_last%0d", nm, k), cap[k].l, tbl[i].exp_last);
        end else begin
          chk($sformatf("%s_missing%0d", nm, k), 0, 1);
        end
        k++;
      end
    end
  endtask

  // Real-data bursts: words in FIFO order, never padded, last on every BL-th word
  task automatic check_real(input string nm);
    chk({nm, "_count"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++) begin
      chk($sformatf("%s_dat%0d", nm, i), cap[i].d, expq[i]);
      chk($sformatf("%s_pad%0d", nm, i), cap[i].p, 0);
      chk($sformatf("%s_last%0d", nm, i), cap[i].l, (i % BL) == (BL - 1));
    end
  endtask

  task automatic run_until(input int n, input int bound);
    for (int i = 0; i < bound && cap.size() < n; i++) cyc();
  endtask

  task automatic load(input int force_filled);
    fifo_empty   = (fq.size() == 0);
    filled_force = force_filled;
    fifo_filled  = (force_filled == 1) ? 1'b1 : (fq.size() >= BL);
  endtask

  initial begin
    int empty_cnt;

    tbl[0]  = '{0, 8'h11, 1'b0, 1'b0};
    tbl[1]  = '{0, 8'h12, 1'b0, 1'b0};
    tbl[2]  = '{0, 8'h13, 1'b0, 1'b0};
    tbl[3]  = '{0, 8'h14, 1'b0, 1'b1};
    tbl[4]  = '{0, 8'h15, 1'b0, 1'b0};
    tbl[5]  = '{0, 8'h16, 1'b0, 1'b0};
    tbl[6]  = '{0, 8'h17, 1'b0, 1'b0};
    tbl[7]  = '{0, 8'h18, 1'b0, 1'b1};
    tbl[8]  = '{1, 8'hA1, 1'b0, 1'b0};
    tbl[9]  = '{1, 8'hA2, 1'b0, 1'b0};
    tbl[10] = '{1, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{1, 8'h00, 1'b1, 1'b1};

    rst = 1'b1; fifo_empty = 1'b1; fifo_filled = 1'b0; fifo_rdata = 8'h00;
    flush = 1'b0; burst_ack = 1'b0; out_ready = 1'b1;
    ack_mode = 0; ready_mode = 0; filled_force = 0; ack_hold = 0;
    cyc_no = 0; first_deq = -1; first_vld = -1; n_deq = 0; n_xfer = 0; low_ack_cycles = 0;
    feed_en = 0; feed_rand = 0; chk_ackwait = 0; hs_pending = 0; prev_vld_nr = 0; prev_last_xfer = 0;
    prev_dat = 8'h00;

    // Reset state
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_req", burst_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_pad", out_pad, 0);
    chk("rst_busy", busy, 0);
    chk("rst_deq", fifo_dequeue, 0);

    // Two back-to-back bursts, ack one cycle after request
    ack_mode = 1; ready_mode = 0;
    fq = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    load(0);
    cap.delete(); first_deq = -1; first_vld = -1;
    run_until(8, 200);
    chk("t1_count", cap.size(), 8);
    cmp_tbl(0, "t1");
    chk("t1_latency", first_vld - first_deq, 2);
    repeat (3) cyc();

    // Output backpressure with ready toggling every cycle
    ack_mode = 0; ready_mode = 1;
    fq = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    expq = fq;
    load(0);
    cap.delete();
    run_until(8, 300);
    check_real("t2");
    ready_mode = 0;
    repeat (3) cyc();

    // Flush while the FIFO is empty must leave the engine idle
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("t3_idle%0d", i), busy, 0);
    end

    // Flush of a 2-word tail: padded up to a full burst; dropping flush mid-burst changes nothing
    fq = {8'hA1, 8'hA2};
    load(0);
    cap.delete();
    for (int i = 0; i < 300 && cap.size() < 4; i++) begin
      cyc();
      if (busy) flush = 1'b0;
    end
    flush = 1'b0;
    chk("t3_count", cap.size(), 4);
    cmp_tbl(1, "t3");
    repeat (3) cyc();

    // FIFO runs dry mid-burst without flush: issue stalls, no padding, burst resumes intact
    fq = {8'hD1, 8'hD2};
    src = {8'hD3, 8'hD4};
    expq = {8'hD1, 8'hD2, 8'hD3, 8'hD4};
    feed_en = 0; feed_rand = 0;
    load(1);
    cap.delete();
    for (int i = 0; i < 50 && !busy; i++) cyc();
    filled_force = 0;
    empty_cnt = 0;
    for (int i = 0; i < 100 && empty_cnt < 5; i++) begin
      cyc();
      if (busy && fifo_empty) empty_cnt++;
    end
    chk("t4_stall_seen", empty_cnt, 5);
    chk("t4_still_busy", busy, 1);
    feed_en = 1;
    run_until(4, 200);
    check_real("t4");
    feed_en = 0;
    repeat (3) cyc();

    // Reset in the middle of a burst, then a clean new burst
    fq = {8'hB1, 8'hB2, 8'hB3, 8'hB4};
    load(0);
    cap.delete();
    run_until(2, 200);
    chk("t5_two_sent", cap.size(), 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t5_req", burst_req, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_last", out_last, 0);
    chk("t5_pad", out_pad, 0);
    chk("t5_busy", busy, 0);
    chk("t5_deq", fifo_dequeue, 0);
    fq.delete();
    fq = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    expq = fq;
    load(0);
    cap.delete();
    run_until(4, 200);
    check_real("t5");
    repeat (3) cyc();

    // Acknowledge withheld for 10 request cycles
    ack_mode = 2; ack_hold = 10; low_ack_cycles = 0; chk_ackwait = 1;
    burst_ack = 1'b0;
    fq = {8'hE1, 8'hE2, 8'hE3, 8'hE4};
    expq = fq;
    load(0);
    cap.delete();
    run_until(4, 200);
    chk("t6_wait_cycles", low_ack_cycles, 10);
    chk_ackwait = 0;
    check_real("t6");
    ack_mode = 0;
    repeat (3) cyc();

    // Randomized drain: random FIFO fill timing, random ack and ready
    src.delete();
    for (int i = 0; i < 40; i++) src.push_back(8'($urandom_range(0, 255)));
    expq = src;
    fq.delete();
    load(0);
    ack_mode = 3; ready_mode = 2; feed_en = 1; feed_rand = 1;
    cap.delete();
    run_until(40, 5000);
    check_real("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
